// File: rtl/bp_fe_instr_sequencer.sv
// Front-end instruction sequencer: splits aligned 32-bit fetch words into RISC-V
// 16/32-bit instructions, stitches word-straddling 32-bit instructions, and scans each one.

module bp_fe_instr_scan (
    input  logic [31:0] i_instr,
    output logic [25:0] o_scan
);

    logic        w_branch;
    logic        w_jal;
    logic        w_jalr;
    logic        w_call;
    logic        w_ret;
    logic [20:0] w_imm;

    // x1/x5 are the link registers for return-address-stack hints
    function automatic logic is_link(input logic [4:0] reg_idx);
        is_link = (reg_idx == 5'd1) || (reg_idx == 5'd5);
    endfunction

    // Control-flow decode of 32-bit and compressed encodings; imm is the signed pc-relative offset
    always_comb begin
        w_branch = 1'b0;
        w_jal    = 1'b0;
        w_jalr   = 1'b0;
        w_call   = 1'b0;
        w_ret    = 1'b0;
        w_imm    = 21'd0;
        if (i_instr[1:0] == 2'b11) begin
            case (i_instr[6:0])
                7'b1101111: begin
                    w_jal  = 1'b1;
                    w_call = is_link(i_instr[11:7]);
                    w_imm  = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                end
                7'b1100111: begin
                    w_jalr = 1'b1;
                    w_call = is_link(i_instr[11:7]);
                    w_ret  = (i_instr[11:7] == 5'd0) && is_link(i_instr[19:15]);
                end
                7'b1100011: begin
                    w_branch = 1'b1;
                    w_imm    = {{8{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                                i_instr[11:8], 1'b0};
                end
                default: begin
                    w_branch = 1'b0;
                end
            endcase
        end else begin
            case ({i_instr[15:13], i_instr[1:0]})
                5'b10101: begin
                    w_jal = 1'b1;
                    w_imm = {{9{i_instr[12]}}, i_instr[12], i_instr[8], i_instr[10:9], i_instr[6],
                             i_instr[7], i_instr[2], i_instr[11], i_instr[5:3], 1'b0};
                end
                5'b11001, 5'b11101: begin
                    w_branch = 1'b1;
                    w_imm    = {{12{i_instr[12]}}, i_instr[12], i_instr[6:5], i_instr[2],
                                i_instr[11:10], i_instr[4:3], 1'b0};
                end
                5'b10010: begin
                    // c.jr when bit 12 is clear, c.jalr (always links x1) when set
                    w_jalr = (i_instr[6:2] == 5'd0) && (i_instr[11:7] != 5'd0);
                    w_call = w_jalr && i_instr[12];
                    w_ret  = w_jalr && !i_instr[12] && is_link(i_instr[11:7]);
                end
                default: begin
                    w_branch = 1'b0;
                end
            endcase
        end
    end

    assign o_scan = {w_branch, w_jal, w_jalr, w_call, w_ret, w_imm};

endmodule

module bp_fe_instr_sequencer_chk (
    input logic clk_i,
    input logic reset_i,
    input logic fetch_v_i,
    input logic fetch_pc_lsb_i,
    input logic instr_v_i,
    input logic instr_yumi_i
);

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i)
        instr_yumi_i |-> instr_v_i);

    a_fetch_pc_halfword: assert property (@(posedge clk_i) disable iff (!reset_i)
        fetch_v_i |-> !fetch_pc_lsb_i);

endmodule

module bp_fe_instr_sequencer #(
    parameter int vaddr_width_p  = 39,
    parameter int instr_width_gp = 32,
    localparam int instr_scan_width_lp = 26
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           fetch_v_i,
    input  logic [vaddr_width_p-1:0]       fetch_pc_i,
    input  logic [31:0]                    fetch_data_i,
    output logic                           fetch_yumi_o,
    output logic                           instr_v_o,
    output logic [vaddr_width_p-1:0]       instr_pc_o,
    output logic [instr_width_gp-1:0]      instr_o,
    output logic                           compressed_o,
    output logic [instr_scan_width_lp-1:0] scan_o,
    input  logic                           instr_yumi_i
);

    logic                      r_half_v;
    logic [15:0]               r_half;
    logic [vaddr_width_p-1:0]  r_half_pc;
    logic                      r_offset;

    logic                      w_half_v_nxt;
    logic [15:0]               w_half_nxt;
    logic [vaddr_width_p-1:0]  w_half_pc_nxt;
    logic                      w_offset_nxt;

    logic                      w_v;
    logic                      w_fetch_yumi;
    logic [instr_width_gp-1:0] w_instr;
    logic [vaddr_width_p-1:0]  w_pc;
    logic                      w_compressed;

    logic                      w_pos_hi;
    logic                      w_low_c;
    logic                      w_up_c;
    logic [vaddr_width_p-1:0]  w_word_pc;
    logic [vaddr_width_p-1:0]  w_upper_pc;

    assign w_pos_hi   = r_offset | fetch_pc_i[1];
    assign w_low_c    = (fetch_data_i[1:0] != 2'b11);
    assign w_up_c     = (fetch_data_i[17:16] != 2'b11);
    assign w_word_pc  = {fetch_pc_i[vaddr_width_p-1:2], 2'b00};
    assign w_upper_pc = {fetch_pc_i[vaddr_width_p-1:2], 2'b10};

    // Presentation and next-state selection; outputs stay zero whenever nothing is presented
    always_comb begin
        w_v           = 1'b0;
        w_fetch_yumi  = 1'b0;
        w_instr       = {instr_width_gp{1'b0}};
        w_pc          = {vaddr_width_p{1'b0}};
        w_compressed  = 1'b0;
        w_half_v_nxt  = r_half_v;
        w_half_nxt    = r_half;
        w_half_pc_nxt = r_half_pc;
        w_offset_nxt  = r_offset;
        if (flush_i) begin
            w_half_v_nxt  = 1'b0;
            w_half_nxt    = 16'd0;
            w_half_pc_nxt = {vaddr_width_p{1'b0}};
            w_offset_nxt  = 1'b0;
        end else if (r_half_v) begin
            if (fetch_v_i) begin
                // Held upper part of a straddler completes with the low half of this word
                w_v     = 1'b1;
                w_instr = {fetch_data_i[15:0], r_half};
                w_pc    = r_half_pc;
                if (instr_yumi_i) begin
                    w_half_v_nxt = 1'b0;
                    w_offset_nxt = 1'b1;
                end else begin
                    w_half_v_nxt = r_half_v;
                end
            end else begin
                w_v = 1'b0;
            end
        end else if (fetch_v_i) begin
            if (!w_pos_hi) begin
                w_v  = 1'b1;
                w_pc = w_word_pc;
                if (w_low_c) begin
                    w_instr      = {16'd0, fetch_data_i[15:0]};
                    w_compressed = 1'b1;
                    w_offset_nxt = instr_yumi_i ? 1'b1 : r_offset;
                end else begin
                    w_instr      = fetch_data_i;
                    w_fetch_yumi = instr_yumi_i;
                end
            end else if (w_up_c) begin
                w_v          = 1'b1;
                w_pc         = w_upper_pc;
                w_instr      = {16'd0, fetch_data_i[31:16]};
                w_compressed = 1'b1;
                w_fetch_yumi = instr_yumi_i;
                w_offset_nxt = instr_yumi_i ? 1'b0 : r_offset;
            end else begin
                // Upper half starts a 32-bit instruction: capture it and release the word
                w_fetch_yumi  = 1'b1;
                w_half_v_nxt  = 1'b1;
                w_half_nxt    = fetch_data_i[31:16];
                w_half_pc_nxt = w_upper_pc;
                w_offset_nxt  = 1'b0;
            end
        end else begin
            w_v = 1'b0;
        end
    end

    // Held-half and word-offset state
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_half_v  <= 1'b0;
            r_half    <= 16'd0;
            r_half_pc <= {vaddr_width_p{1'b0}};
            r_offset  <= 1'b0;
        end else begin
            r_half_v  <= w_half_v_nxt;
            r_half    <= w_half_nxt;
            r_half_pc <= w_half_pc_nxt;
            r_offset  <= w_offset_nxt;
        end
    end

    bp_fe_instr_scan u_scan (
        .i_instr (w_instr[31:0]),
        .o_scan  (scan_o)
    );

    bp_fe_instr_sequencer_chk u_chk (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .fetch_v_i      (fetch_v_i),
        .fetch_pc_lsb_i (fetch_pc_i[0]),
        .instr_v_i      (instr_v_o),
        .instr_yumi_i   (instr_yumi_i)
    );

    assign instr_v_o    = w_v;
    assign fetch_yumi_o = w_fetch_yumi;
    assign instr_o      = w_instr;
    assign instr_pc_o   = w_pc;
    assign compressed_o = w_compressed;

endmodule
